// File: rtl/nibble_add_seq.sv
// nibble_add_seq: performs one W-bit addition (W = 4*NIB) as NIB nibble steps
// on an external 4-bit adder, least-significant nibble first, chaining the
// carry between steps and assembling the wide result, cout and overflow flag.
module nibble_add_seq #(
  parameter int NIB = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4*NIB-1:0] op_a,
  input  logic [4*NIB-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [4*NIB-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int W    = 4 * NIB;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_lat_q, a_lat_d;
  logic [W-1:0]    b_lat_q, b_lat_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic            last_nib;

  assign last_nib = (idx_q == IDXW'(NIB - 1));

  // Select the operand nibbles addressed by the current step index.
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int k = 0; k < NIB; k++) begin
      if (idx_q == IDXW'(k)) begin
        nib_a = a_lat_q[4*k +: 4];
        nib_b = b_lat_q[4*k +: 4];
      end
    end
  end

  // State register plus all datapath flops; reset aborts any sequence in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_lat_q  <= '0;
      b_lat_q  <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_lat_q  <= a_lat_d;
      b_lat_q  <= b_lat_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic: start is only honoured in IDLE, the unused code recovers to IDLE.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = last_nib ? DONE : RUN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch operands on accept, capture one sum nibble per RUN cycle.
  always_comb begin
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_lat_d  = a_lat_q;
    b_lat_d  = b_lat_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_lat_d  = op_a;
          b_lat_d  = op_b;
          carry_d  = cin;
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      RUN: begin
        for (int k = 0; k < NIB; k++) begin
          if (idx_q == IDXW'(k)) begin
            result_d[4*k +: 4] = add_sum;
          end
        end
        carry_d = add_cout;
        if (last_nib) begin
          idx_d  = '0;
          cout_d = add_cout;
          ovf_d  = (a_lat_q[W-1] == b_lat_q[W-1]) && (add_sum[3] != a_lat_q[W-1]);
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: begin
        idx_d = idx_q;
      end
    endcase
  end

  // Output decode: handshake from state, adder inputs only driven while running.
  always_comb begin
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = nib_a;
      add_b   = nib_b;
      add_cin = carry_q;
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq: directed checks of the nibble-serial add sequencer with a
// behavioural 4-bit adder attached, for a two-nibble and a one-nibble build.
module tb_nibble_add_seq;

  logic clk = 1'b0;
  logic rst;

  // Two-nibble instance signals
  logic       start;
  logic [7:0] opA, opB;
  logic       cinIn;
  logic       busy, done;
  logic [7:0] result;
  logic       cout, ovf;
  logic [3:0] addA, addB, addSum;
  logic       addCin, addCout;

  // One-nibble instance signals
  logic       start1;
  logic [3:0] opA1, opB1;
  logic       cin1;
  logic       busy1, done1;
  logic [3:0] result1;
  logic       cout1, ovf1;
  logic [3:0] addA1, addB1, addSum1;
  logic       addCin1, addCout1;

  int testsRun = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  // Behavioural model of the shared 4-bit adder for each instance
  assign {addCout, addSum}   = {1'b0, addA} + {1'b0, addB} + {4'b0, addCin};
  assign {addCout1, addSum1} = {1'b0, addA1} + {1'b0, addB1} + {4'b0, addCin1};

  nibble_add_seq #(.NIB(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op_a(opA), .op_b(opB), .cin(cinIn),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf),
    .add_a(addA), .add_b(addB), .add_cin(addCin),
    .add_sum(addSum), .add_cout(addCout)
  );

  nibble_add_seq #(.NIB(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_a(opA1), .op_b(opB1), .cin(cin1),
    .busy(busy1), .done(done1), .result(result1), .cout(cout1), .ovf(ovf1),
    .add_a(addA1), .add_b(addB1), .add_cin(addCin1),
    .add_sum(addSum1), .add_cout(addCout1)
  );

  // Count one comparison and report it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present operands with a one-cycle start pulse; returns in the first RUN cycle
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    opA   = a;
    opB   = b;
    cinIn = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait a bounded number of cycles for done on the two-nibble instance
  task automatic waitDone(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < limit);
  endtask

  // One full addition with its nibble drives, latency and results checked
  task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] expResult, input logic expCout, input logic expOvf,
                       input logic expCarry1);
    int cycles;
    applyStimulus(a, b, c);
    checkOutput({tag, "_busy0"}, 32'(busy), 32'd1);
    checkOutput({tag, "_adda0"}, 32'(addA), 32'(a[3:0]));
    checkOutput({tag, "_addb0"}, 32'(addB), 32'(b[3:0]));
    checkOutput({tag, "_cin0"}, 32'(addCin), 32'(c));
    @(negedge clk);
    checkOutput({tag, "_adda1"}, 32'(addA), 32'(a[7:4]));
    checkOutput({tag, "_addb1"}, 32'(addB), 32'(b[7:4]));
    checkOutput({tag, "_cin1"}, 32'(addCin), 32'(expCarry1));
    waitDone(8, cycles);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'd1);
    checkOutput({tag, "_result"}, 32'(result), 32'(expResult));
    checkOutput({tag, "_cout"}, 32'(cout), 32'(expCout));
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(expOvf));
    checkOutput({tag, "_busyDone"}, 32'(busy), 32'd0);
    checkOutput({tag, "_adderIdle"}, 32'({addA, addB, addCin}), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_donePulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_resultHold"}, 32'(result), 32'(expResult));
  endtask

  // Abort the run with a hard failure if the sequence never completes
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence
  initial begin
    int cycles;
    int doneSeen;
    rst    = 1'b1;
    start  = 1'b0;
    opA    = 8'h00;
    opB    = 8'h00;
    cinIn  = 1'b0;
    start1 = 1'b0;
    opA1   = 4'h0;
    opB1   = 4'h0;
    cin1   = 1'b0;

    #2;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_flags", 32'({cout, ovf}), 32'd0);
    checkOutput("reset_adder", 32'({addA, addB, addCin}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic add, carry chain through both nibbles, and signed overflow cases
    runOp("add2A12", 8'h2A, 8'h12, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    runOp("addFF01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    runOp("add7F00", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1);
    runOp("add8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // Start held high: back-to-back operations every fourth edge, latched operands
    @(negedge clk);
    opA   = 8'h01;
    opB   = 8'h01;
    cinIn = 1'b0;
    start = 1'b1;
    @(negedge clk);
    checkOutput("hold_busy", 32'(busy), 32'd1);
    opA = 8'h55;
    waitDone(8, cycles);
    checkOutput("hold_firstLatency", 32'(cycles), 32'd2);
    checkOutput("hold_firstResult", 32'(result), 32'h02);
    waitDone(8, cycles);
    checkOutput("hold_spacing", 32'(cycles), 32'd4);
    checkOutput("hold_secondResult", 32'(result), 32'h56);
    start = 1'b0;
    @(negedge clk);
    checkOutput("hold_idle", 32'({busy, done}), 32'd0);
    @(negedge clk);
    checkOutput("hold_noRestart", 32'(busy), 32'd0);

    // Reset during the first RUN cycle aborts the operation without a done pulse
    applyStimulus(8'h2A, 8'h12, 1'b0);
    checkOutput("abort_busyBefore", 32'(busy), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_result", 32'(result), 32'd0);
    checkOutput("abort_flags", 32'({cout, ovf}), 32'd0);
    checkOutput("abort_adder", 32'({addA, addB, addCin}), 32'd0);
    doneSeen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("abort_noDone", 32'(doneSeen), 32'd0);
    runOp("add0401", 8'h04, 8'h01, 1'b1, 8'h06, 1'b0, 1'b0, 1'b0);

    // Single-nibble build: one RUN cycle then a single done cycle
    @(negedge clk);
    opA1   = 4'h9;
    opB1   = 4'h8;
    cin1   = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checkOutput("n1_busy", 32'(busy1), 32'd1);
    checkOutput("n1_adda", 32'(addA1), 32'h9);
    checkOutput("n1_cin", 32'(addCin1), 32'd1);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done1 && cycles < 8);
    checkOutput("n1_done", 32'(done1), 32'd1);
    checkOutput("n1_latency", 32'(cycles), 32'd1);
    checkOutput("n1_result", 32'(result1), 32'h2);
    checkOutput("n1_cout", 32'(cout1), 32'd1);
    checkOutput("n1_ovf", 32'(ovf1), 32'd1);
    @(negedge clk);
    checkOutput("n1_donePulse", 32'(done1), 32'd0);
    checkOutput("n1_resultHold", 32'(result1), 32'h2);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/nibble_add_seq.md
Name: nibble_add_seq

Overview:
- Sequencer that performs one wide addition as a series of nibble-serial steps on the shared 4-bit adder (ports a, b, cin in; sum, cout out).
- Owns the adder's inputs, chains the carry between nibbles, and assembles the wide result.
- Sits between the operand/key-input logic and the 4-bit adder. Start/busy/done handshake to the upstream side.

Parameters:
NIB, 2, number of nibbles per operand (operand width W = 4*NIB). Legal range 1..8.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  request a new addition; sampled only in IDLE
op_a  input  W  operand A
op_b  input  W  operand B
cin  input  1  carry-in for the least-significant nibble
busy  output  1  high while the sequence is in progress (RUN state)
done  output  1  one-cycle pulse: result, cout and ovf are valid
result  output  W  assembled sum
cout  output  1  carry out of the most-significant nibble
ovf  output  1  two's-complement overflow of the W-bit addition
add_a  output  4  nibble of A driven to the adder
add_b  output  4  nibble of B driven to the adder
add_cin  output  1  carry driven to the adder
add_sum  input  4  adder sum, combinational from add_a/add_b/add_cin
add_cout  input  1  adder carry-out

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0; internal idx=0, carry=0, operand latches=0. add_a/add_b/add_cin=0.
- States: IDLE, RUN, DONE. Use a 2-bit encoding; the unused code returns to IDLE.
- IDLE:
  - On start=1 at a clock edge: latch op_a, op_b; carry<=cin; idx<=0; result<=0; cout<=0; ovf<=0; go to RUN.
  - start=0: remain in IDLE.
- RUN:
  - busy=1.
  - Combinational drive: add_a=A_lat[4*idx+3:4*idx], add_b=B_lat nibble idx, add_cin=carry.
  - Each edge: result nibble idx<=add_sum; carry<=add_cout; idx<=idx+1.
  - On the edge where idx==NIB-1: cout<=add_cout; ovf<=(A_lat[W-1]==B_lat[W-1]) && (add_sum[3]!=A_lat[W-1]); go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Latency: with start sampled at edge 0, nibble captures occur at edges 1..NIB. done is high between edges NIB and NIB+1. Next start is accepted at edge NIB+1 or later.
- When not in RUN, adder drive outputs are 0.
- start while in RUN or DONE: ignored, with no queueing. The operand latches are unaffected by op_a/op_b changes after the start edge.
- result, cout and ovf hold their values after done until the next accepted start clears them.
- Arithmetic: unsigned result = (A + B + cin) mod 2^W, with cout = bit W of the sum. ovf uses the signed interpretation and includes cin.
- NIB=1: RUN lasts one cycle; done is high in the cycle after start plus one.
- Reset asserted mid-RUN: the sequence is aborted immediately and all outputs go to their reset values. No done pulse is produced for the aborted operation.

Test Plan:
- NIB=2, cin=0, A=0x2A, B=0x12, 1-cycle start → add_a=0xA,0x2 on successive RUN cycles; done at cycle 3; result=0x3C, cout=0, ovf=0.
- cin=0, A=0xFF, B=0x01 → inter-nibble carry propagates (add_cin=1 in the second RUN cycle); result=0x00, cout=1, ovf=0.
- cin=1, A=0x7F, B=0x00 → result=0x80, cout=0, ovf=1. Then A=0x80, B=0x80, cin=0 → result=0x00, cout=1, ovf=1.
- Hold start high continuously with A=0x01, B=0x01 → an operation is accepted every 4th edge (IDLE, RUN, RUN, DONE). Changes to op_a during RUN do not alter the result (0x02).
- Assert rst during the first RUN cycle → busy, done, result, cout and ovf are 0 immediately, with no done pulse. After release, A=0x04, B=0x01, cin=1 → result=0x06.
- NIB=1 build: A=0x9, B=0x8, cin=1 → result=0x2, cout=1, ovf=1; done high exactly one cycle, 2 edges after start.
